sseg_scan_controller: RTL and testbench
=======================================

SSEG_SCAN_CONTROLLER -- requirements
Module: sseg_scan_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter GUARD_CYCLES, default 2, cycles of anode blanking at the start of each slot; legal range 1..REFRESH_DIV-2.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  16  four hex digits; [3:0] = digit0 (rightmost), [15:12] = digit3.
REQ-006 load_req  input  1  level request to update the displayed value from data_in.
REQ-007 load_ack  output  1  one-cycle pulse when data_in is captured.
REQ-008 digit_en  input  4  per-digit enable mask; bit i gates digit i.
REQ-009 an  output  4  active-low anode select, at most one bit low at any time.
REQ-010 sseg  output  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
REQ-011 frame_tick  output  1  one-cycle pulse at the first cycle of digit0's slot.

Function
REQ-012 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; slot_end is asserted when count = REFRESH_DIV-1.
REQ-013 Digit index SHALL advance 0->1->2->3->0 on slot_end, wrapping from 3 to 0.
REQ-014 FSM states: GUARD (an=4'b1111, sseg=7'b1111111) for the first GUARD_CYCLES cycles of a slot, then DRIVE until slot_end, then GUARD for the next slot.
REQ-015 In DRIVE, an[idx]=0 and the other bits =1, unless digit idx is suppressed (REQ-017/REQ-022), in which case an=4'b1111.
REQ-016 sseg in DRIVE SHALL be the registered hex decode of shadow nibble idx: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-017 digit_en[idx]=0 SHALL suppress digit idx for the whole slot; digit_en is sampled at slot start.
REQ-018 Shadow register SHALL capture data_in only on the cycle the index wraps 3->0 while load_req=1; load_ack pulses high on that same cycle's registered output (one cycle later).
REQ-019 load_req deasserted before the wrap SHALL cause no capture; load_req held high SHALL capture once per frame, with one load_ack per capture.
REQ-020 data_in changes mid-frame SHALL NOT alter the displayed value before the next wrap (no tearing).
REQ-021 frame_tick and load_ack SHALL be registered, glitch-free, and coincident when a capture occurs.

Configuration
REQ-022 Macro SSEG_LEADING_ZERO_BLANK_EN: when defined, digits 3..1 that are zero and above the most significant nonzero shadow digit are suppressed, and digit0 is always shown; when undefined, all enabled digits are shown, including zeros.

Reset
REQ-023 reset=0 SHALL immediately force an=4'b1111, sseg=7'b1111111, load_ack=0, frame_tick=0, shadow=16'h0000, idx=0, prescaler=0, FSM=GUARD.
REQ-024 After release, first slot SHALL be digit0 with frame_tick on the first post-reset cycle; reset mid-slot SHALL abort the slot with no partial drive.

Verification (REFRESH_DIV=4, GUARD_CYCLES=1)
REQ-025 Reset release, data_in=16'h1234, load_req=1 -> load_ack at first wrap; subsequent frame shows an=1110/sseg=7'h19, 1101/7'h30, 1011/7'h24, 0111/7'h79, each for 3 cycles after 1 guard cycle.
REQ-026 data_in changed to 16'hABCD mid-frame with load_req=0 -> display stays 1234; set load_req=1 -> switches exactly at next wrap with one load_ack.
REQ-027 digit_en=4'b0101, shadow 16'hFFFF -> an never drives digits 1 and 3; digits 0 and 2 show 7'h0E.
REQ-028 Macro defined, shadow 16'h0007 -> only digit0 driven (7'h78); shadow 16'h0000 -> digit0 shows 7'h40; macro undefined -> all four digits are driven.
REQ-029 Assert reset during digit2 DRIVE -> an=1111 and sseg=7'h7F in the same cycle; shadow=0; restart at digit0.
REQ-030 Checker on all scenarios: an never has two bits low; frame_tick period = 4*REFRESH_DIV cycles.

Source files
------------

// File: rtl/sseg_scan_controller.sv
// sseg_scan_controller
//
// Time-multiplexed driver for a four-digit, common-anode seven-segment
// display. Each digit owns a slot of REFRESH_DIV clock cycles; the first
// GUARD_CYCLES cycles of every slot blank the anodes so a segment pattern
// never bleeds into the neighbouring digit. The displayed value comes from
// a shadow register that is refreshed only at frame boundaries, so a value
// never tears across a frame.
//
// Parameters:
//   REFRESH_DIV   clock cycles per digit slot (4 .. 2**20)
//   GUARD_CYCLES  blanking cycles at the start of each slot (1 .. REFRESH_DIV-2)
//
// Ports:
//   i_clk         system clock, all state on the rising edge
//   i_rst_n       asynchronous active-low reset
//   i_data_in     four hex digits, [3:0] = digit0 (rightmost) .. [15:12] = digit3
//   i_load_req    level request to capture i_data_in at the next frame start
//   o_load_ack    one-cycle pulse, coincident with o_frame_tick, per capture
//   i_digit_en    per-digit enable mask, sampled at the start of each slot
//   o_an          active-low anode select, at most one bit low
//   o_sseg        active-low cathodes, bit order {g,f,e,d,c,b,a}
//   o_frame_tick  one-cycle pulse on the first cycle of digit0's slot
//
// Optional feature (compile-time macro):
//   SSEG_LEADING_ZERO_BLANK_EN  when defined, zero digits above the most
//                               significant nonzero digit are blanked
//                               (digit0 is always shown).
//
// Output timing: the registered outputs describe the slot position held by
// the counters one cycle earlier, which is why the first cycle after reset
// release is already the first cycle of digit0's slot.

module sseg_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_data_in,
  input  logic        i_load_req,
  output logic        o_load_ack,
  input  logic [3:0]  i_digit_en,
  output logic [3:0]  o_an,
  output logic [6:0]  o_sseg,
  output logic        o_frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LEN  = CNT_W'(GUARD_CYCLES);

  typedef enum logic {
    ST_GUARD,
    ST_DRIVE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_idx;
  logic [15:0]      r_shadow;
  logic             r_slotEn;

  logic             w_slotEnd;
  logic             w_frameStart;
  logic [3:0]       w_nibble;
  logic [3:0]       w_blank;
  logic             w_show;
  logic [3:0]       w_driveAn;
  logic [6:0]       w_driveSseg;

  // Active-low hex decode, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hexDecode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // The frame starts on the first cycle after the digit index has wrapped
  // from 3 back to 0; this is the only cycle on which the shadow register
  // may change, and it always falls inside digit0's guard interval.
  assign w_slotEnd    = (r_count == LAST_COUNT);
  assign w_frameStart = (r_idx == 2'd0) && (r_count == '0);

  // Select the shadow nibble belonging to the digit being scanned.
  always_comb begin
    w_nibble = r_shadow[3:0];
    case (r_idx)
      2'd0: w_nibble = r_shadow[3:0];
      2'd1: w_nibble = r_shadow[7:4];
      2'd2: w_nibble = r_shadow[11:8];
      2'd3: w_nibble = r_shadow[15:12];
      default: w_nibble = r_shadow[3:0];
    endcase
  end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // A digit is blanked only if it and every digit above it are zero;
  // digit0 is never blanked so a zero value still shows "0".
  always_comb begin
    w_blank    = 4'b0000;
    w_blank[3] = (r_shadow[15:12] == 4'h0);
    w_blank[2] = w_blank[3] && (r_shadow[11:8] == 4'h0);
    w_blank[1] = w_blank[2] && (r_shadow[7:4] == 4'h0);
    w_blank[0] = 1'b0;
  end
`else
  assign w_blank = 4'b0000;
`endif

  // Values the outputs take during a drive cycle. A suppressed digit keeps
  // every anode off for its whole slot.
  always_comb begin
    w_show      = r_slotEn && !w_blank[r_idx];
    w_driveAn   = 4'b1111;
    w_driveSseg = 7'h7F;
    if (w_show) begin
      w_driveAn   = ~(4'b0001 << r_idx);
      w_driveSseg = hexDecode(w_nibble);
    end
  end

  // Slot prescaler, digit index and shadow register. The index is two bits
  // wide so it wraps 3 -> 0 on its own.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_idx    <= 2'd0;
      r_shadow <= 16'h0000;
    end else begin
      if (w_slotEnd) begin
        r_count <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_frameStart && i_load_req) begin
        r_shadow <= i_data_in;
      end
    end
  end

  // Guard/drive FSM with all display outputs registered. The digit enable
  // is latched on the first cycle of each slot; since the guard interval is
  // at least one cycle, the latched value is in place before any drive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_GUARD;
      r_slotEn     <= 1'b0;
      o_an         <= 4'b1111;
      o_sseg       <= 7'h7F;
      o_load_ack   <= 1'b0;
      o_frame_tick <= 1'b0;
    end else begin
      o_frame_tick <= w_frameStart;
      o_load_ack   <= w_frameStart && i_load_req;

      if (r_count == '0) begin
        r_slotEn <= i_digit_en[r_idx];
      end

      case (r_state)
        ST_GUARD: begin
          if (r_count >= GUARD_LEN) begin
            r_state <= ST_DRIVE;
            o_an    <= w_driveAn;
            o_sseg  <= w_driveSseg;
          end else begin
            o_an    <= 4'b1111;
            o_sseg  <= 7'h7F;
          end
        end
        ST_DRIVE: begin
          if (r_count == '0) begin
            r_state <= ST_GUARD;
            o_an    <= 4'b1111;
            o_sseg  <= 7'h7F;
          end else begin
            o_an    <= w_driveAn;
            o_sseg  <= w_driveSseg;
          end
        end
        default: begin
          r_state <= ST_GUARD;
          o_an    <= 4'b1111;
          o_sseg  <= 7'h7F;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// tb_sseg_scan_controller
//
// Directed bench for sseg_scan_controller with REFRESH_DIV=4 and
// GUARD_CYCLES=1, so one frame is 16 cycles: per digit one guard cycle and
// three drive cycles. Expected display values come from a hand-written
// decode table and hand-chosen digit masks per scenario.

module tb_sseg_scan_controller;

  localparam int REFRESH_DIV  = 4;
  localparam int GUARD_CYCLES = 1;
  localparam int FRAME_LEN    = 4 * REFRESH_DIV;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ_MASK = 4'b0001;
`else
  localparam logic [3:0] LZ_MASK = 4'b1111;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] dataIn;
  logic        loadReq;
  logic        loadAck;
  logic [3:0]  digitEn;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        frameTick;

  int checkCount;
  int errorCount;
  int cycleCount;
  int lastTickCycle;
  bit haveLastTick;

  logic [6:0] segTable [16];

  sseg_scan_controller #(
    .REFRESH_DIV  (REFRESH_DIV),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data_in    (dataIn),
    .i_load_req   (loadReq),
    .o_load_ack   (loadAck),
    .i_digit_en   (digitEn),
    .o_an         (an),
    .o_sseg       (sseg),
    .o_frame_tick (frameTick)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure the frame_tick period.
  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] data, input logic req,
                               input logic [3:0] en);
    dataIn  = data;
    loadReq = req;
    digitEn = en;
  endtask

  // Walks one full frame, sampling on each falling edge. Must be called on
  // the falling edge just before the frame's first cycle.
  task automatic checkFrame(input string tag, input logic [15:0] expVal,
                            input logic [3:0] expMask, input logic expAck);
    int d;
    int c;
    logic [3:0] nib;
    logic [3:0] expAn;
    for (int n = 0; n < FRAME_LEN; n++) begin
      @(negedge clk);
      d = n / REFRESH_DIV;
      c = n % REFRESH_DIV;
      if (n == 0) begin
        checkOutput($sformatf("%s_tick", tag), {31'd0, frameTick}, 32'd1);
        checkOutput($sformatf("%s_ack", tag), {31'd0, loadAck}, {31'd0, expAck});
      end else begin
        checkOutput($sformatf("%s_tick_n%0d", tag, n), {31'd0, frameTick}, 32'd0);
        checkOutput($sformatf("%s_ack_n%0d", tag, n), {31'd0, loadAck}, 32'd0);
      end
      if (c < GUARD_CYCLES) begin
        checkOutput($sformatf("%s_guard_an_d%0d", tag, d), {28'd0, an}, 32'hF);
        checkOutput($sformatf("%s_guard_seg_d%0d", tag, d), {25'd0, sseg}, 32'h7F);
      end else if (expMask[d]) begin
        nib      = expVal[d*4 +: 4];
        expAn    = 4'b1111;
        expAn[d] = 1'b0;
        checkOutput($sformatf("%s_an_d%0d_c%0d", tag, d, c), {28'd0, an}, {28'd0, expAn});
        checkOutput($sformatf("%s_seg_d%0d_c%0d", tag, d, c), {25'd0, sseg},
                    {25'd0, segTable[nib]});
      end else begin
        checkOutput($sformatf("%s_off_an_d%0d_c%0d", tag, d, c), {28'd0, an}, 32'hF);
      end
    end
  endtask

  // Continuous checks: at most one anode low, and a constant frame period
  // between frame ticks that are not separated by a reset.
  always @(negedge clk) begin
    checkOutput("an_onehot", {31'd0, ($countones(~an) <= 1)}, 32'd1);
    if (!rst_n) begin
      haveLastTick = 1'b0;
    end else if (frameTick) begin
      if (haveLastTick) begin
        checkOutput("tick_period", cycleCount - lastTickCycle, FRAME_LEN);
      end
      lastTickCycle = cycleCount;
      haveLastTick  = 1'b1;
    end
  end

  initial begin
    segTable = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    checkCount    = 0;
    errorCount    = 0;
    cycleCount    = 0;
    lastTickCycle = 0;
    haveLastTick  = 1'b0;
    rst_n         = 1'b0;
    applyStimulus(16'h1234, 1'b1, 4'b1111);

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_an", {28'd0, an}, 32'hF);
    checkOutput("rst_seg", {25'd0, sseg}, 32'h7F);
    checkOutput("rst_ack", {31'd0, loadAck}, 32'd0);
    checkOutput("rst_tick", {31'd0, frameTick}, 32'd0);
    rst_n = 1'b1;

    // First frame after release captures 1234 and shows it.
    checkFrame("f1234", 16'h1234, 4'b1111, 1'b1);

    // No request: new data is ignored, including a change mid-frame.
    applyStimulus(16'hABCD, 1'b0, 4'b1111);
    fork
      checkFrame("hold", 16'h1234, 4'b1111, 1'b0);
      begin
        repeat (6) @(negedge clk);
        dataIn = 16'h5555;
      end
    join

    // Request raised: switches exactly at the next frame with one ack.
    applyStimulus(16'hABCD, 1'b1, 4'b1111);
    checkFrame("fABCD", 16'hABCD, 4'b1111, 1'b1);

    // Digit mask 0101 on FFFF: digits 1 and 3 stay dark.
    applyStimulus(16'hFFFF, 1'b1, 4'b0101);
    checkFrame("mask", 16'hFFFF, 4'b0101, 1'b1);

    // Leading-zero cases (all digits driven when blanking is not built in).
    applyStimulus(16'h0007, 1'b1, 4'b1111);
    checkFrame("lz7", 16'h0007, LZ_MASK, 1'b1);
    applyStimulus(16'h0000, 1'b1, 4'b1111);
    checkFrame("lz0", 16'h0000, LZ_MASK, 1'b1);

    // Reload 1234, then reset in the middle of digit2's drive interval.
    applyStimulus(16'h1234, 1'b1, 4'b1111);
    checkFrame("pre_rst", 16'h1234, 4'b1111, 1'b1);
    applyStimulus(16'h1234, 1'b0, 4'b1111);
    repeat (10) @(negedge clk);
    checkOutput("mid_an_d2", {28'd0, an}, 32'hB);
    checkOutput("mid_seg_d2", {25'd0, sseg}, 32'h24);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_an", {28'd0, an}, 32'hF);
    checkOutput("arst_seg", {25'd0, sseg}, 32'h7F);
    checkOutput("arst_ack", {31'd0, loadAck}, 32'd0);
    checkOutput("arst_tick", {31'd0, frameTick}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Restart at digit0 with a cleared shadow register.
    checkFrame("post_rst", 16'h0000, LZ_MASK, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
